// File: rtl/mem_wb_unit.sv
// Memory-access / writeback stage: byte-serial LOAD/STORE over an 8-bit memory port, then one WB cycle.
// Optional build macro WB_X0_FILTER_EN suppresses register-file writes to x0.
module mem_wb_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    output logic        rf_signal,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        WB    = 2'd3
    } state_t;

    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

`ifdef WB_X0_FILTER_EN
    localparam logic X0_FILTER = 1'b1;
`else
    localparam logic X0_FILTER = 1'b0;
`endif

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [31:0] bytes_r, bytes_s;
    logic [1:0]  op_r;
    logic [2:0]  f3_r;
    logic [31:0] addr_r;
    logic [31:0] sdata_r;
    logic [4:0]  rd_r;
    logic        rf_signal_r, rf_signal_s;
    logic [4:0]  rf_rd_r, rf_rd_s;
    logic [31:0] rf_data_r, rf_data_s;
    logic        done_r, done_s;
    logic        accept_s;
    logic [2:0]  n_s;

    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   extend = f3[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   extend = f3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    function automatic logic rf_enable(input logic is_write, input logic [4:0] idx);
        rf_enable = is_write && !(X0_FILTER && (idx == 5'd0));
    endfunction

    assign accept_s  = (state_r == IDLE) && in_valid && rdy_in;
    assign n_s       = byte_count(f3_r);
    assign in_ready  = (state_r == IDLE);
    assign rf_signal = rf_signal_r;
    assign rf_rd     = rf_rd_r;
    assign rf_data   = rf_data_r;
    assign done      = done_r;

    // Next-state, byte capture and writeback-register values
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bytes_s     = bytes_r;
        rf_signal_s = rf_signal_r;
        rf_rd_s     = rf_rd_r;
        rf_data_s   = rf_data_r;
        done_s      = done_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_s   = 3'd0;
                    bytes_s = 32'd0;
                    case (op)
                        OP_LOAD:  state_s = LOAD;
                        OP_STORE: state_s = STORE;
                        OP_ALU: begin
                            state_s     = WB;
                            rf_signal_s = rf_enable(1'b1, rd);
                            rf_rd_s     = rd;
                            rf_data_s   = alu_result;
                            done_s      = 1'b1;
                        end
                        default: begin
                            state_s     = WB;
                            rf_signal_s = 1'b0;
                            rf_rd_s     = rd;
                            rf_data_s   = 32'd0;
                            done_s      = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (rdy_in) begin
                    // mem_din answers the address presented in the previous cycle
                    if (cnt_r != 3'd0) begin
                        bytes_s[{cnt_r[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
                    end else begin
                        bytes_s = bytes_r;
                    end
                    if (cnt_r == n_s) begin
                        state_s     = WB;
                        rf_signal_s = rf_enable(op_r == OP_LOAD, rd_r);
                        rf_rd_s     = rd_r;
                        rf_data_s   = extend(bytes_s, f3_r);
                        done_s      = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            STORE: begin
                if (rdy_in) begin
                    if (cnt_r == n_s - 3'd1) begin
                        state_s     = WB;
                        rf_signal_s = 1'b0;
                        rf_rd_s     = rd_r;
                        rf_data_s   = 32'd0;
                        done_s      = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end else begin
                    state_s = STORE;
                end
            end
            WB: begin
                if (rdy_in) begin
                    state_s     = IDLE;
                    cnt_s       = 3'd0;
                    rf_signal_s = 1'b0;
                    rf_rd_s     = 5'd0;
                    rf_data_s   = 32'd0;
                    done_s      = 1'b0;
                end else begin
                    state_s = WB;
                end
            end
            default: begin
                state_s     = IDLE;
                cnt_s       = 3'd0;
                rf_signal_s = 1'b0;
                done_s      = 1'b0;
            end
        endcase
    end

    // State, counter and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            bytes_r     <= 32'd0;
            rf_signal_r <= 1'b0;
            rf_rd_r     <= 5'd0;
            rf_data_r   <= 32'd0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bytes_r     <= bytes_s;
            rf_signal_r <= rf_signal_s;
            rf_rd_r     <= rf_rd_s;
            rf_data_r   <= rf_data_s;
            done_r      <= done_s;
        end
    end

    // Operand latch, loaded only when an op is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= 2'd0;
            f3_r    <= 3'd0;
            addr_r  <= 32'd0;
            sdata_r <= 32'd0;
            rd_r    <= 5'd0;
        end else if (accept_s) begin
            op_r    <= op;
            f3_r    <= funct3;
            addr_r  <= addr;
            sdata_r <= store_data;
            rd_r    <= rd;
        end
    end

    // Memory port decoded from registered state so a freeze acts in the same cycle;
    // a frozen LOAD re-presents the address of the byte it could not capture.
    always_comb begin
        mem_a    = 32'd0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        case (state_r)
            LOAD: begin
                if (!rdy_in && (cnt_r != 3'd0)) begin
                    mem_a = addr_r + {29'd0, cnt_r} - 32'd1;
                end else begin
                    mem_a = addr_r + {29'd0, cnt_r};
                end
            end
            STORE: begin
                mem_a    = addr_r + {29'd0, cnt_r};
                mem_wr   = rdy_in;
                mem_dout = sdata_r[{cnt_r[1:0], 3'b000} +: 8];
            end
            default: begin
                mem_a    = 32'd0;
                mem_wr   = 1'b0;
                mem_dout = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_wb_unit.sv
// Randomized self-checking bench for mem_wb_unit against a per-op behavioural model.
module tb_mem_wb_unit;

    logic        clk = 1'b0;
    logic        rst, rdy_in, in_valid, in_ready;
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [31:0] addr, alu_result, store_data;
    logic [4:0]  rd;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic        rf_signal;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        done;

    int total = 0;
    int bad   = 0;
    bit stall_en = 1'b0;

`ifdef WB_X0_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_wb_unit dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .addr(addr), .alu_result(alu_result),
        .store_data(store_data), .rd(rd), .mem_din(mem_din), .mem_a(mem_a),
        .mem_wr(mem_wr), .mem_dout(mem_dout), .rf_signal(rf_signal), .rf_rd(rf_rd),
        .rf_data(rf_data), .done(done)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] h;
        if (a == 32'h100) return 8'h80;
        if (a >= 32'h200 && a <= 32'h203) return 8'((a - 32'h1FF) * 32'h11);
        h = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        return h;
    endfunction

    // synchronous read memory: data one cycle after the address
    always @(posedge clk) mem_din <= mem_byte(mem_a);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rdy_in = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
    endtask

    function automatic int nbytes(input logic [2:0] f);
        return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        int n;
        logic [31:0] raw;
        n = nbytes(f);
        raw = 32'd0;
        for (int i = 0; i < n; i++) raw = raw | (32'(mem_byte(a + 32'(i))) << (8 * i));
        if (n < 4 && !f[2] && raw[8 * n - 1]) raw = raw | (32'hFFFF_FFFF << (8 * n));
        return raw;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] al, input logic [31:0] sd, input logic [4:0] r);
        int n, exp_lat, rdycnt, wr_k, ld_k, guard;
        bit seen_done, finished, exp_sig;
        logic [31:0] exp_data;
        n        = nbytes(f);
        exp_lat  = (o == 2'b10) ? n + 1 : (o == 2'b11) ? n : 0;
        exp_sig  = ((o == 2'b01) || (o == 2'b10)) && !(FILTER && r == 5'd0);
        exp_data = (o == 2'b01) ? al : (o == 2'b10) ? model_load(a, f) : 32'd0;
        op = o; funct3 = f; addr = a; alu_result = al; store_data = sd; rd = r;
        in_valid = 1'b1;
        guard = 0;
        while (!(in_ready && rdy_in) && guard < 50) begin
            step();
            guard++;
        end
        check_eq("accept", {31'd0, in_ready && rdy_in}, 32'd1);
        step();
        // scramble inputs: the unit must work from its latched copy
        in_valid = 1'b0;
        op = 2'($urandom); funct3 = 3'($urandom); addr = $urandom;
        alu_result = $urandom; store_data = $urandom; rd = 5'($urandom);
        rdycnt = 0; wr_k = 0; ld_k = 0; guard = 0;
        seen_done = 1'b0; finished = 1'b0;
        while (!finished && guard < 100) begin
            if (done) begin
                if (!seen_done) begin
                    check_eq("latency", rdycnt, exp_lat);
                    check_eq("rf_signal", {31'd0, rf_signal}, {31'd0, exp_sig});
                    check_eq("rf_rd", {27'd0, rf_rd}, {27'd0, r});
                    if (exp_sig || o == 2'b10) check_eq("rf_data", rf_data, exp_data);
                    if (o == 2'b11) check_eq("st_count", wr_k, n);
                    seen_done = 1'b1;
                end else begin
                    check_eq("wb_hold", {31'd0, rf_signal}, {31'd0, exp_sig});
                end
                check_eq("wb_busy", {31'd0, in_ready}, 32'd0);
                check_eq("wb_wr", {31'd0, mem_wr}, 32'd0);
                if (rdy_in) finished = 1'b1;
            end else begin
                if (seen_done) check_eq("wb_drop", {31'd0, done}, 32'd1);
                check_eq("no_rf", {31'd0, rf_signal}, 32'd0);
                check_eq("busy", {31'd0, in_ready}, 32'd0);
                if (!rdy_in) check_eq("frz_wr", {31'd0, mem_wr}, 32'd0);
                if (mem_wr) begin
                    check_eq("st_a", mem_a, a + 32'(wr_k));
                    check_eq("st_d", {24'd0, mem_dout}, (sd >> (8 * wr_k)) & 32'hFF);
                    wr_k++;
                end
                if (o == 2'b10) begin
                    check_eq("ld_wr", {31'd0, mem_wr}, 32'd0);
                    if (rdy_in && ld_k < n) begin
                        check_eq("ld_a", mem_a, a + 32'(ld_k));
                        ld_k++;
                    end
                end
                if (rdy_in) rdycnt++;
            end
            if (!finished) begin
                step();
                guard++;
            end
        end
        check_eq("op_end", {31'd0, finished}, 32'd1);
        step();
        check_eq("idle_ready", {31'd0, in_ready}, 32'd1);
        check_eq("idle_done", {31'd0, done}, 32'd0);
    endtask

    task automatic reset_mid_load();
        stall_en = 1'b0;
        op = 2'b10; funct3 = 3'b010; addr = 32'h200; rd = 5'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check_eq("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_mid_done", {31'd0, done}, 32'd0);
        check_eq("rst_mid_sig", {31'd0, rf_signal}, 32'd0);
        check_eq("rst_mid_a", mem_a, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("rst_no_wb", {30'd0, done, rf_signal}, 32'd0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3_tab [6];
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        rst = 1'b1; rdy_in = 1'b1; in_valid = 1'b1; op = 2'b01; funct3 = 3'd0;
        addr = 32'd0; alu_result = 32'hDEAD_BEEF; store_data = 32'd0; rd = 5'd3;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sig", {31'd0, rf_signal}, 32'd0);
        check_eq("rst_rd", {27'd0, rf_rd}, 32'd0);
        check_eq("rst_data", rf_data, 32'd0);
        check_eq("rst_mem", {mem_a[22:0], mem_wr, mem_dout}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        run_op(2'b01, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 5'd5);
        run_op(2'b10, 3'b000, 32'h100, 32'h0, 32'h0, 5'd7);
        run_op(2'b10, 3'b100, 32'h100, 32'h0, 32'h0, 5'd7);
        run_op(2'b10, 3'b010, 32'h200, 32'h0, 32'h0, 5'd8);
        run_op(2'b11, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0000_ABCD, 5'd4);
        run_op(2'b01, 3'b000, 32'h0, 32'hCAFE_F00D, 32'h0, 5'd0);
        run_op(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd1);
        reset_mid_load();

        stall_en = 1'b1;
        run_op(2'b10, 3'b010, 32'h200, 32'h0, 32'h0, 5'd3);
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            run_op(2'($urandom), f3_tab[$urandom_range(0, 5)], a, $urandom, $urandom,
                   5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_unit.md
MEM_WB_UNIT -- requirements
Module: mem_wb_unit

Interface
REQ-001 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  rdy_in  in  1  global enable; 0 = freeze
  in_valid  in  1  upstream op valid
  in_ready  out  1  block can accept an op
  op  in  2  00 NOP, 01 ALU, 10 LOAD, 11 STORE
  funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
  addr  in  32  memory byte address (LOAD/STORE)
  alu_result  in  32  value to write back (ALU)
  store_data  in  32  value to store (STORE)
  rd  in  5  destination register index
  mem_din  in  8  memory read byte
  mem_a  out  32  memory byte address
  mem_wr  out  1  1 = write, 0 = read
  mem_dout  out  8  memory write byte
  rf_signal  out  1  register-file write enable (RF_WRITE)
  rf_rd  out  5  register-file write index
  rf_data  out  32  register-file write data
  done  out  1  one-cycle op-complete pulse

Function
REQ-003 SHALL implement states IDLE, LOAD, STORE and WB.
REQ-004 SHALL drive in_ready=1 only in IDLE.
REQ-005 SHALL accept an op on a rising edge with in_valid=1, in_ready=1, rdy_in=1, and SHALL latch op, funct3, addr, alu_result, store_data and rd at that edge.
REQ-006 Transitions SHALL be: on accept, NOP or ALU -> WB, LOAD -> LOAD, STORE -> STORE; from WB -> IDLE after one cycle.
REQ-007 Byte count n SHALL be 1 for funct3[1:0]=00, 2 for 01, and 4 for 10 or 11; funct3 011 SHALL behave as W.
REQ-008 LOAD SHALL use counter c from 0 to n.
  - While c<n: drive mem_a=addr+c and mem_wr=0.
  - While c>=1: capture mem_din as byte c-1.
  - When c=n: go to WB.
  - LOAD therefore lasts n+1 cycles.
REQ-009 mem_din SHALL be treated as valid exactly one cycle after its address is presented.
REQ-010 Loaded bytes SHALL be assembled little-endian.
REQ-011 Loaded data SHALL be sign-extended when funct3[2]=0 and zero-extended when funct3[2]=1; W ignores funct3[2].
REQ-012 STORE SHALL run c from 0 to n-1, driving mem_wr=1, mem_a=addr+c and mem_dout=store_data[8c+7:8c]; after cycle n-1 it SHALL go to WB.
REQ-013 WB SHALL last exactly one cycle with done=1, rf_rd=latched rd, and:
  - rf_signal=1 for ALU and LOAD; rf_signal=0 for NOP and STORE.
  - rf_data=alu_result for ALU; rf_data=assembled value for LOAD.
REQ-014 rf_signal and done SHALL be 0 outside WB.
REQ-015 mem_wr SHALL be 0 outside STORE.
REQ-016 Address arithmetic SHALL be modulo 2^32 (addr 0xFFFFFFFF+1 wraps to 0).
REQ-017 While rdy_in=0, state, counter, captured bytes and latched inputs SHALL hold, mem_wr SHALL be forced 0, and no op SHALL be accepted.
REQ-018 A byte due for capture while rdy_in=0 SHALL NOT be captured; its address SHALL be re-presented when rdy_in returns.
REQ-019 The WB state SHALL not advance while rdy_in=0, so rf_signal and done stay high until the first cycle with rdy_in=1.
REQ-020 Back-to-back ops SHALL be supported: an op may be accepted in the cycle immediately after WB.

Reset
REQ-021 On rst=1 at a rising edge, the block SHALL:
  - enter IDLE and clear c;
  - set mem_a=0, mem_wr=0, mem_dout=0, rf_signal=0, rf_rd=0, rf_data=0, done=0.
REQ-022 Reset SHALL take priority over rdy_in and in_valid.
REQ-023 Reset mid-LOAD or mid-STORE SHALL abort the op with no writeback and no further memory write.

Configuration
REQ-024 SHALL support macro WB_X0_FILTER_EN.
  - Defined: rf_signal SHALL be 0 in WB whenever latched rd=0; done still pulses.
  - Undefined: rd=0 writes are issued as normal, and the register file handles them.

Verification
REQ-025 ALU op, rd=5, alu_result=0x12345678 -> in the cycle after accept: rf_signal=1, rf_rd=5, rf_data=0x12345678, done=1; in_ready=1 the following cycle.
REQ-026 LB addr=0x100, mem[0x100]=0x80 -> mem_a=0x100 with mem_wr=0 for one cycle; LOAD lasts 2 cycles; rf_data=0xFFFFFF80. Repeat with LBU -> rf_data=0x00000080.
REQ-027 LW addr=0x200, mem bytes 0x11,0x22,0x33,0x44 -> mem_a sequence 0x200..0x203; WB on cycle 6 after accept; rf_data=0x44332211.
REQ-028 SH addr=0xFFFFFFFF, store_data=0xABCD -> two write cycles: (0xFFFFFFFF, 0xCD) then (0x00000000, 0xAB); rf_signal stays 0; done=1.
REQ-029 LW with rdy_in=0 for 3 cycles mid-LOAD -> mem_wr=0, state holds, result identical to the uninterrupted run. Separately, rst asserted at c=2 -> IDLE next cycle with no rf_signal pulse.
REQ-030 ALU op with rd=0 -> rf_signal=0 in WB with WB_X0_FILTER_EN defined; rf_signal=1 without it.
